// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the RV32I core.
// Owns PC and IR, fetches over an imem req/ack bus and steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, driving dmem requests and the RF write strobe.
// Optional macro CTRL_PERF_CNT_EN adds cycle / retired-instruction counters;
// without it cycle_cnt and instret_cnt are tied to zero.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        illegal,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [31:0] wb_data,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  trap_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value seen during the last permitted request cycle.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     alu_q, alu_d;
  logic [31:0]     load_q, load_d;
  logic [1:0]      cause_q, cause_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  // Access kind captured in EXEC so dmem_we / wb_data stay stable after decode.
  logic            we_q, we_d;
  logic            ld_q, ld_d;

  logic [31:0]     pc_inc;
  logic [31:0]     br_target;

  assign pc_inc    = pc_q + 32'd4;
  assign br_target = pc_q + (alu_result[0] ? imm : 32'd4);

  // Next-state and register-update logic for the sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    alu_d   = alu_q;
    load_d  = load_q;
    cause_d = cause_q;
    tmo_d   = '0;
    we_d    = we_q;
    ld_d    = ld_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          cause_d = 2'd2;
          state_d = S_TRAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          cause_d = 2'd1;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_d = alu_result;
        we_d  = mem_write;
        ld_d  = mem_read;
        if (branch) begin
          if (br_target[1:0] != 2'b00) begin
            cause_d = 2'd3;
            state_d = S_TRAP;
          end else begin
            pc_d    = br_target;
            state_d = S_FETCH;
          end
        end else if (mem_read || mem_write) begin
          state_d = S_MEM;
        end else if (reg_write) begin
          state_d = S_WB;
        end else begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (we_q) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            load_d  = dmem_rdata;
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          cause_d = 2'd2;
          state_d = S_TRAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_BOOT;
    endcase
  end

  // State and architectural registers; reset forces BOOT and drops any pending ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      alu_q   <= '0;
      load_q  <= '0;
      cause_q <= 2'd0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      load_q  <= load_d;
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ret_q, ret_d;
  logic        retire;

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  // Performance counter next values: active cycles and retirements into FETCH.
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if ((state_q != S_BOOT) && (state_q != S_TRAP)) cyc_d = cyc_q + 32'd1;
    if (retire) ret_d = ret_q + 32'd1;
  end

  // Performance counter registers, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

  // Moore outputs decoded from registered state.
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign instr      = ir_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && we_q;
  assign dmem_addr  = alu_q;
  assign rf_we      = (state_q == S_WB);
  assign wb_data    = ld_q ? load_q : alu_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. The bench stands in for
// imem, dmem, decoder and ALU, driving their outputs directly per test.
module tb_multicycle_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, instr;
  logic        branch, mem_read, mem_write, reg_write, illegal;
  logic [31:0] imm, alu_result;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_rdata;
  logic        rf_we, halted;
  logic [31:0] wb_data, pc, cycle_cnt, instret_cnt;
  logic [1:0]  trap_cause;

  int n_chk = 0;
  int n_err = 0;
  int cnt;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  multicycle_ctrl #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .illegal(illegal), .imm(imm), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .wb_data(wb_data), .pc(pc), .halted(halted), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_dec(input logic br, input logic mr, input logic mw, input logic rw,
                         input logic ill, input logic [31:0] im, input logic [31:0] alu);
    branch = br; mem_read = mr; mem_write = mw; reg_write = rw;
    illegal = ill; imm = im; alu_result = alu;
  endtask

  // Ack in the current FETCH cycle, leaving the DUT in DECODE.
  task automatic fetch(input logic [31:0] w);
    imem_ack = 1'b1; imem_rdata = w;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
  endtask

  // A no-write, non-branch instruction: FETCH, DECODE, EXEC.
  task automatic run_nop();
    set_dec(0, 0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'h0000_0013);
    tick();
    tick();
  endtask

  // Pulse reset, release it, and step past BOOT into FETCH.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=%0t exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    set_dec(0, 0, 0, 0, 0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_cause", {30'h0, trap_cause}, 32'h0);
    chk("rst_strobes", {29'h0, imem_req, dmem_req, rf_we}, 32'h0);
    chk("rst_cyc", cycle_cnt, 32'h0);
    reset = 1'b0;
    chk("boot_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("fetch_req", {31'h0, imem_req}, 32'h1);
    chk("fetch_addr", imem_addr, 32'h0);

    // addi x1,x0,5 with immediate ack
    set_dec(0, 0, 0, 1, 0, 32'h5, 32'h5);
    fetch(32'h0050_0093);
    chk("t1_ir", instr, 32'h0050_0093);
    chk("t1_req_drop", {31'h0, imem_req}, 32'h0);
    tick();
    chk("t1_exec_rfwe", {31'h0, rf_we}, 32'h0);
    tick();
    chk("t1_wb_rfwe", {31'h0, rf_we}, 32'h1);
    chk("t1_wb_data", wb_data, 32'h5);
    tick();
    chk("t1_rfwe_once", {31'h0, rf_we}, 32'h0);
    chk("t1_pc", pc, 32'h4);
    chk("t1_refetch", {31'h0, imem_req}, 32'h1);
    chk("t1_cyc", cycle_cnt, PERF ? 32'd4 : 32'd0);
    chk("t1_ret", instret_cnt, PERF ? 32'd1 : 32'd0);

    // lw with dmem_ack delayed by 3 cycles
    set_dec(0, 1, 0, 1, 0, 32'h0, 32'h100);
    fetch(32'h1000_2083);
    tick();
    tick();
    chk("t2_addr", dmem_addr, 32'h100);
    chk("t2_we", {31'h0, dmem_we}, 32'h0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (dmem_req) cnt++;
      tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    if (dmem_req) cnt++;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("t2_req_cycles", cnt, 32'd4);
    chk("t2_rfwe", {31'h0, rf_we}, 32'h1);
    chk("t2_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("t2_req_drop", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("t2_pc", pc, 32'h8);

    // store with immediate ack: 4 cycles, back in FETCH at pc+4
    set_dec(0, 0, 1, 0, 0, 32'h0, 32'h40);
    fetch(32'h0010_2023);
    tick();
    tick();
    chk("st_req_we", {30'h0, dmem_req, dmem_we}, 32'h3);
    chk("st_addr", dmem_addr, 32'h40);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("st_fetch", {30'h0, imem_req, rf_we}, 32'h2);
    chk("st_pc", pc, 32'hC);
    run_nop();
    chk("nop_pc", pc, 32'h10);

    // beq taken, imm=-8 from pc=16
    set_dec(1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h1);
    fetch(32'hFE00_0CE3);
    tick();
    chk("t3_exec_rfwe", {31'h0, rf_we}, 32'h0);
    tick();
    chk("t3_taken_pc", pc, 32'h8);
    chk("t3_fetch", {30'h0, imem_req, rf_we}, 32'h2);
    run_nop();
    run_nop();
    chk("t3_pc16", pc, 32'h10);

    // beq taken, imm=2 -> misaligned target
    set_dec(1, 0, 0, 0, 0, 32'h2, 32'h1);
    fetch(32'h0000_0163);
    tick();
    tick();
    chk("t3_mis_halt", {31'h0, halted}, 32'h1);
    chk("t3_mis_cause", {30'h0, trap_cause}, 32'h3);
    chk("t3_mis_pc", pc, 32'h10);

    // fetch timeout: no ack for 16 request cycles
    do_reset();
    set_dec(0, 0, 0, 0, 0, 32'h0, 32'h0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (imem_req) cnt++;
      tick();
    end
    chk("t4_req_cycles", cnt, 32'd16);
    chk("t4_halt", {31'h0, halted}, 32'h1);
    chk("t4_cause", {30'h0, trap_cause}, 32'h2);
    chk("t4_pc", pc, 32'h0);

    // ack on request cycle 16 is accepted; the word is illegal
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    chk("t4b_still_req", {30'h0, imem_req, halted}, 32'h2);
    set_dec(0, 0, 0, 0, 1, 32'h0, 32'h0);
    fetch(32'hFFFF_FFFF);
    chk("t4b_accept", {31'h0, halted}, 32'h0);
    chk("t5_ir", instr, 32'hFFFF_FFFF);
    tick();
    chk("t5_halt", {31'h0, halted}, 32'h1);
    chk("t5_cause", {30'h0, trap_cause}, 32'h1);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("t5_held", {28'h0, halted, imem_req, dmem_req, rf_we}, 32'h8);
    chk("t5_cause_held", {30'h0, trap_cause}, 32'h1);

    // reset asserted mid-MEM while dmem_ack arrives
    do_reset();
    set_dec(0, 1, 0, 1, 0, 32'h0, 32'h200);
    fetch(32'h2000_2083);
    tick();
    tick();
    chk("t6_in_mem", {31'h0, dmem_req}, 32'h1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    reset = 1'b1;
    #1;
    chk("t6_async", {30'h0, dmem_req, rf_we}, 32'h0);
    chk("t6_pc", pc, 32'h0);
    chk("t6_cyc", cycle_cnt, 32'h0);
    chk("t6_ret", instret_cnt, 32'h0);
    tick();
    reset = 1'b0;
    chk("t6_boot", {30'h0, imem_req, rf_we}, 32'h0);
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    chk("t6_fetch", {30'h0, imem_req, rf_we}, 32'h2);
    chk("t6_wb_clear", wb_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
